// File: rtl/game_countdown_timer_pkg.sv
// Shared definitions for the game countdown timer, the game state machine and the
// on-screen time overlay.
package game_countdown_timer_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StExpired = 2'd2
  } timer_state_e;

  localparam int unsigned DefaultClkFreqHz   = 65_000_000;
  localparam int unsigned DefaultGameSeconds = 60;

  // Packs a 0..99 value as {tens, ones} BCD digits.
  function automatic logic [7:0] to_bcd(input int unsigned value);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'((value / 10) % 10);
    ones = 4'(value % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/game_countdown_timer_bcd_down_counter.sv
// Two-digit BCD down-counter with parallel load, decrement enable and zero flag.
// A decrement at zero is ignored so the digits never wrap.
module bcd_down_counter #(
  parameter logic [7:0] ResetValue = 8'h00
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_value_i,
  input  logic       dec_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       zero_o
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  assign zero_o = (tens_q == 4'd0) && (ones_q == 4'd0);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (load_i) begin
      tens_d = load_value_i[7:4];
      ones_d = load_value_i[3:0];
    end else if (dec_i && !zero_o) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= ResetValue[7:4];
      ones_q <= ResetValue[3:0];
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule

// File: rtl/game_countdown_timer.sv
// Game-length countdown: 1 s prescaler from pclk, binary and BCD seconds remaining,
// and the game_timer level consumed by the game state machine.
module game_countdown_timer
  import game_countdown_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = DefaultClkFreqHz,
  parameter int unsigned GAME_SECONDS = DefaultGameSeconds
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       game_timer,
  output logic [6:0] seconds_left,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       sec_tick,
  output logic       expired
);

  localparam int unsigned      PrescW   = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(CLK_FREQ_HZ - 1);
  localparam logic [6:0]        GameSecs = 7'(GAME_SECONDS);
  localparam logic [7:0]        GameBcd  = to_bcd(GAME_SECONDS);

  timer_state_e      state_q, state_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [6:0]        secs_q, secs_d;
  logic              tick_q, tick_d;
  logic              expired_q, expired_d;
  logic              bcd_load, bcd_dec, bcd_zero;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    secs_d    = secs_q;
    tick_d    = 1'b0;
    expired_d = 1'b0;
    bcd_load  = 1'b0;
    bcd_dec   = 1'b0;
    if (abort) begin
      state_d  = StIdle;
      presc_d  = '0;
      secs_d   = GameSecs;
      bcd_load = 1'b1;
    end else if (start) begin
      state_d  = StRun;
      presc_d  = '0;
      secs_d   = GameSecs;
      bcd_load = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (presc_q == PrescMax) begin
            presc_d = '0;
            tick_d  = 1'b1;
            secs_d  = secs_q - 7'd1;
            bcd_dec = 1'b1;
            // bcd_zero only matters if the count were somehow already at zero.
            if (secs_q == 7'd1 || bcd_zero) begin
              secs_d    = '0;
              state_d   = StExpired;
              expired_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PrescW'(1);
          end
        end
        StExpired: begin
          presc_d = '0;
          secs_d  = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      secs_q    <= GameSecs;
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      secs_q    <= secs_d;
      tick_q    <= tick_d;
      expired_q <= expired_d;
    end
  end

  bcd_down_counter #(
    .ResetValue (GameBcd)
  ) u_bcd (
    .pclk         (pclk),
    .rst_n        (rst_n),
    .load_i       (bcd_load),
    .load_value_i (GameBcd),
    .dec_i        (bcd_dec),
    .tens_o       (sec_tens),
    .ones_o       (sec_ones),
    .zero_o       (bcd_zero)
  );

  assign game_timer   = (state_q != StExpired);
  assign seconds_left = secs_q;
  assign sec_tick     = tick_q;
  assign expired      = expired_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Bench for game_countdown_timer: scenario tables with a cycle scoreboard on a
// 3 s instance, plus hand sequences on a 20 s instance and for asynchronous reset.
module tb_game_countdown_timer;

  localparam int unsigned Freq  = 4;
  localparam int unsigned GameA = 3;
  localparam int unsigned GameB = 20;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic       gt_a, tick_a, exp_a, gt_b, tick_b, exp_b;
  logic [6:0] secs_a, secs_b;
  logic [3:0] tens_a, ones_a, tens_b, ones_b;

  always #5 pclk = ~pclk;

  game_countdown_timer #(.CLK_FREQ_HZ(Freq), .GAME_SECONDS(GameA)) dut_a (
    .pclk(pclk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .game_timer(gt_a),
    .seconds_left(secs_a), .sec_tens(tens_a), .sec_ones(ones_a), .sec_tick(tick_a),
    .expired(exp_a)
  );

  game_countdown_timer #(.CLK_FREQ_HZ(Freq), .GAME_SECONDS(GameB)) dut_b (
    .pclk(pclk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .game_timer(gt_b),
    .seconds_left(secs_b), .sec_tens(tens_b), .sec_ones(ones_b), .sec_tick(tick_b),
    .expired(exp_b)
  );

  typedef struct {
    int scen; int cyc; bit start; bit abort; bit chk; bit gt; int secs; bit tick; bit ex;
  } vec_t;
  typedef struct {bit gt; int secs; bit tick; bit ex;} out_t;

  vec_t vecs[$];
  out_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   m_state, m_presc, m_secs;

  task automatic check(input string name, input int cyc, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic void stim(input int sc, input int c, input bit s, input bit a);
    vec_t v;
    v = '{scen: sc, cyc: c, start: s, abort: a, chk: 1'b0, gt: 1'b0, secs: 0, tick: 1'b0,
          ex: 1'b0};
    vecs.push_back(v);
  endfunction

  function automatic void want(input int sc, input int c, input bit gt, input int secs,
                               input bit tick, input bit ex);
    vec_t v;
    v = '{scen: sc, cyc: c, start: 1'b0, abort: 1'b0, chk: 1'b1, gt: gt, secs: secs,
          tick: tick, ex: ex};
    vecs.push_back(v);
  endfunction

  // Reference: 0 idle, 1 run, 2 expired; returns outputs for the following cycle.
  function automatic out_t model_step(input bit s, input bit a);
    out_t o;
    o.tick = 1'b0;
    o.ex   = 1'b0;
    if (a) begin
      m_state = 0; m_presc = 0; m_secs = GameA;
    end else if (s) begin
      m_state = 1; m_presc = 0; m_secs = GameA;
    end else if (m_state == 1) begin
      if (m_presc == Freq - 1) begin
        m_presc = 0;
        m_secs  = m_secs - 1;
        o.tick  = 1'b1;
        if (m_secs == 0) begin
          m_state = 2;
          o.ex    = 1'b1;
        end
      end else begin
        m_presc = m_presc + 1;
      end
    end else if (m_state == 2) begin
      m_presc = 0;
    end
    o.gt   = (m_state != 2);
    o.secs = m_secs;
    return o;
  endfunction

  task automatic reset_all();
    out_t r;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    repeat (3) @(posedge pclk);
    #1 rst_n = 1'b1;
    m_state = 0; m_presc = 0; m_secs = GameA;
    sb.delete();
    r = '{gt: 1'b1, secs: GameA, tick: 1'b0, ex: 1'b0};
    sb.push_back(r);
  endtask

  task automatic run_scen(input int sc, input int ncyc);
    reset_all();
    for (int c = 0; c <= ncyc; c++) begin
      bit   s, a;
      out_t e;
      s = 1'b0;
      a = 1'b0;
      foreach (vecs[i]) if (vecs[i].scen == sc && vecs[i].cyc == c) begin
        s = s | vecs[i].start;
        a = a | vecs[i].abort;
      end
      start_a = s;
      abort_a = a;
      sb.push_back(model_step(s, a));
      @(negedge pclk);
      e = sb.pop_front();
      check("sb_game_timer", c, int'(gt_a), int'(e.gt));
      check("sb_seconds_left", c, int'(secs_a), e.secs);
      check("sb_sec_tens", c, int'(tens_a), e.secs / 10);
      check("sb_sec_ones", c, int'(ones_a), e.secs % 10);
      check("sb_sec_tick", c, int'(tick_a), int'(e.tick));
      check("sb_expired", c, int'(exp_a), int'(e.ex));
      foreach (vecs[i]) if (vecs[i].scen == sc && vecs[i].cyc == c && vecs[i].chk) begin
        check("tbl_game_timer", c, int'(gt_a), int'(vecs[i].gt));
        check("tbl_seconds_left", c, int'(secs_a), vecs[i].secs);
        check("tbl_sec_tick", c, int'(tick_a), int'(vecs[i].tick));
        check("tbl_expired", c, int'(exp_a), int'(vecs[i].ex));
      end
      @(posedge pclk);
      #1;
    end
    start_a = 1'b0;
    abort_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    // 1: idle after reset, no ticks.
    want(1, 0, 1, 3, 0, 0); want(1, 49, 1, 3, 0, 0);
    // 2: full countdown from start at cycle 10, then parked in EXPIRED.
    stim(2, 10, 1, 0);
    want(2, 11, 1, 3, 0, 0); want(2, 14, 1, 3, 0, 0); want(2, 15, 1, 2, 1, 0);
    want(2, 16, 1, 2, 0, 0); want(2, 19, 1, 1, 1, 0); want(2, 22, 1, 1, 0, 0);
    want(2, 23, 0, 0, 1, 1); want(2, 24, 0, 0, 0, 0); want(2, 43, 0, 0, 0, 0);
    // 3: abort mid-count.
    stim(3, 10, 1, 0); stim(3, 17, 0, 1);
    want(3, 15, 1, 2, 1, 0); want(3, 18, 1, 3, 0, 0); want(3, 19, 1, 3, 0, 0);
    // 4: start+abort together, then restart from EXPIRED.
    stim(4, 10, 1, 0); stim(4, 13, 1, 1); stim(4, 20, 1, 0); stim(4, 36, 1, 0);
    want(4, 14, 1, 3, 0, 0); want(4, 15, 1, 3, 0, 0); want(4, 18, 1, 3, 0, 0);
    want(4, 25, 1, 2, 1, 0); want(4, 33, 0, 0, 1, 1); want(4, 36, 0, 0, 0, 0);
    want(4, 37, 1, 3, 0, 0); want(4, 41, 1, 2, 1, 0);

    run_scen(1, 50);
    run_scen(2, 44);
    run_scen(3, 25);
    run_scen(4, 42);

    // 20 s instance: BCD borrow and binary/BCD agreement at every tick.
    reset_all();
    check("b_reset_secs", 0, int'(secs_b), 20);
    check("b_reset_tens", 0, int'(tens_b), 2);
    check("b_reset_ones", 0, int'(ones_b), 0);
    start_b = 1'b1;
    @(posedge pclk);
    #1 start_b = 1'b0;
    for (int k = 1; k <= int'(GameB); k++) begin
      found = 1'b0;
      for (int w = 0; w < 8 && !found; w++) begin
        @(negedge pclk);
        found = tick_b;
      end
      check("b_tick_seen", k, int'(found), 1);
      check("b_secs", k, int'(secs_b), int'(GameB) - k);
      check("b_bcd_agree", k, int'(tens_b) * 10 + int'(ones_b), int'(secs_b));
      if (k == 1) begin
        check("b_tens_after_1", k, int'(tens_b), 1);
        check("b_ones_after_1", k, int'(ones_b), 9);
      end
      if (k == 10) begin
        check("b_tens_after_10", k, int'(tens_b), 1);
        check("b_ones_after_10", k, int'(ones_b), 0);
      end
      if (k == int'(GameB)) begin
        check("b_game_timer_end", k, int'(gt_b), 0);
        check("b_expired_end", k, int'(exp_b), 1);
      end
    end

    // Asynchronous reset while sec_tick is high mid-RUN.
    reset_all();
    start_a = 1'b1;
    @(posedge pclk);
    #1 start_a = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 8 && !found; w++) begin
      @(negedge pclk);
      found = tick_a;
    end
    check("rst_pre_tick", 0, int'(found), 1);
    check("rst_pre_secs", 0, int'(secs_a), 2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_game_timer", 0, int'(gt_a), 1);
    check("rst_secs", 0, int'(secs_a), 3);
    check("rst_tens", 0, int'(tens_a), 0);
    check("rst_ones", 0, int'(ones_a), 3);
    check("rst_tick", 0, int'(tick_a), 0);
    check("rst_expired", 0, int'(exp_a), 0);
    @(posedge pclk);
    #1 rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
